// File: rtl/shifter_arbiter.sv
// Two-requester round-robin front end for a single shared shifter.
// Accepts one request at a time, shifts it in one cycle and holds the tagged response until consumed.
module shifter_arbiter #(
  parameter int unsigned OPD_LENGTH = 8,
  parameter int unsigned SHAMT_W    = $clog2(OPD_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [3:0]            req0_op,
  input  logic [OPD_LENGTH-1:0] req0_opd1,
  input  logic [OPD_LENGTH-1:0] req0_opd2,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [3:0]            req1_op,
  input  logic [OPD_LENGTH-1:0] req1_opd1,
  input  logic [OPD_LENGTH-1:0] req1_opd2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [OPD_LENGTH-1:0] rsp_result,
  output logic                  rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] OP_SRL = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRA = 4'b0111;

  logic [1:0]            state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  id_q, id_d;
  logic [3:0]            op_q, op_d;
  logic [OPD_LENGTH-1:0] opd1_q, opd1_d;
  logic [OPD_LENGTH-1:0] opd2_q, opd2_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [OPD_LENGTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  grant_vld;
  logic                  grant_id;
  logic [3:0]            sel_op;
  logic [OPD_LENGTH-1:0] sel_opd1;
  logic [OPD_LENGTH-1:0] sel_opd2;
  logic                  unused_opd2_hi;
  logic [OPD_LENGTH-1:0] shift_res;
  logic                  op_ok;

  // Arbitration: a lone requester wins, a tie goes to the requester named by prio_q.
  assign grant_vld  = req0_valid | req1_valid;
  assign grant_id   = (req0_valid & req1_valid) ? prio_q : req1_valid;
  assign req0_ready = ~rst & (state_q == S_IDLE) & grant_vld & ~grant_id;
  assign req1_ready = ~rst & (state_q == S_IDLE) & grant_vld & grant_id;

  assign sel_op         = grant_id ? req1_op   : req0_op;
  assign sel_opd1       = grant_id ? req1_opd1 : req0_opd1;
  assign sel_opd2       = grant_id ? req1_opd2 : req0_opd2;
  assign unused_opd2_hi = ^sel_opd2[OPD_LENGTH-1:SHAMT_W];

  // Shared shifter, fed only from the operand registers; opd2_q is always below OPD_LENGTH.
  always_comb begin
    shift_res = '0;
    op_ok     = 1'b1;
    case (op_q)
      OP_SLL:  shift_res = opd1_q << opd2_q;
      OP_SRL:  shift_res = opd1_q >> opd2_q;
      OP_SRA:  shift_res = OPD_LENGTH'($signed(opd1_q) >>> opd2_q);
      default: op_ok     = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    id_d         = id_q;
    op_d         = op_q;
    opd1_d       = opd1_q;
    opd2_d       = opd2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          op_d    = sel_op;
          opd1_d  = sel_opd1;
          opd2_d  = OPD_LENGTH'(sel_opd2[SHAMT_W-1:0]);
          id_d    = grant_id;
          prio_d  = ~grant_id;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_result_d = op_ok ? shift_res : '0;
        rsp_err_d    = ~op_ok;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prio_q       <= 1'b0;
      id_q         <= 1'b0;
      op_q         <= '0;
      opd1_q       <= '0;
      opd2_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      id_q         <= id_d;
      op_q         <= op_d;
      opd1_q       <= opd1_d;
      opd2_q       <= opd2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter: latency, arithmetic, fairness, backpressure and reset abort.
module tb_shifter_arbiter;

  localparam int unsigned W = 8;
  localparam logic [3:0] SRL = 4'b0001;
  localparam logic [3:0] SLL = 4'b0011;
  localparam logic [3:0] SRA = 4'b0111;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_opd1, req0_opd2, req1_opd1, req1_opd2;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  shifter_arbiter #(.OPD_LENGTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_opd1(req0_opd1), .req0_opd2(req0_opd2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_opd1(req1_opd1), .req1_opd2(req1_opd2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_req(input bit which, input logic v, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (!which) begin
      req0_valid = v; req0_op = op; req0_opd1 = a; req0_opd2 = b;
    end else begin
      req1_valid = v; req1_op = op; req1_opd1 = a; req1_opd2 = b;
    end
  endtask

  // Holds one requester valid until accepted; returns just after the accepting edge.
  task automatic issue(input bit which, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output bit ok);
    ok = 1'b0;
    set_req(which, 1'b1, op, a, b);
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if ((!which && req0_ready) || (which && req1_ready)) ok = 1'b1;
      @(posedge clk); #1;
    end
    set_req(which, 1'b0, 4'h0, '0, '0);
  endtask

  task automatic wait_rsp(output bit got, output logic id, output logic [W-1:0] res,
                          output logic err, output int at);
    got = 1'b0; id = 1'b0; res = '0; err = 1'b0; at = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1; id = rsp_id; res = rsp_result; err = rsp_err; at = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, SLL, 8'h01, 8'h01);
    set_req(1, 1'b1, SRL, 8'h80, 8'h01);
    @(posedge clk); @(posedge clk); #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b exp 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b exp 0", req1_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b exp 0", rsp_id); end
    checks++; if (rsp_result !== 8'h00) begin errors++; $display("FAIL reset_rsp_result: got %h exp 00", rsp_result); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b exp 0", rsp_err); end
    set_req(0, 1'b0, 4'h0, '0, '0);
    set_req(1, 1'b0, 4'h0, '0, '0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_latency();
    bit ok;
    issue(0, SLL, 8'h0F, 8'h03, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_accept: got timeout exp accept"); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_exec_valid: got %b exp 0", rsp_valid); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_rsp_valid: got %b exp 1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL basic_id: got %b exp 0", rsp_id); end
    checks++; if (rsp_result !== 8'h78) begin errors++; $display("FAIL basic_result: got %h exp 78", rsp_result); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b exp 0", rsp_err); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_rsp_drop: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_req1_ops();
    logic [3:0]   ops [3] = '{SRL, SRA, SLL};
    logic [W-1:0] a   [3] = '{8'hF0, 8'hE0, 8'h0F};
    logic [W-1:0] b   [3] = '{8'h03, 8'h03, 8'h00};
    logic [W-1:0] exp [3] = '{8'h1E, 8'hFC, 8'h0F};
    bit ok, got; logic id, err; logic [W-1:0] res; int at;
    for (int i = 0; i < 3; i++) begin
      issue(1, ops[i], a[i], b[i], ok);
      wait_rsp(got, id, res, err, at);
      checks++;
      if (!ok || !got || id !== 1'b1 || res !== exp[i] || err !== 1'b0) begin
        errors++;
        $display("FAIL req1_op%0d: got ok=%b rsp=%b id=%b res=%h err=%b exp id=1 res=%h err=0",
                 i, ok, got, id, res, err, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fairness();
    bit got; logic id, err; logic [W-1:0] res; int at, prev_at;
    logic [W-1:0] exp_res;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 1'b1, SLL, 8'h01, 8'h01);
    set_req(1, 1'b1, SRL, 8'h80, 8'h01);
    prev_at = 0;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(got, id, res, err, at);
      exp_res = (i % 2 == 0) ? 8'h02 : 8'h40;
      if (i == 3) begin
        set_req(0, 1'b0, 4'h0, '0, '0);
        set_req(1, 1'b0, 4'h0, '0, '0);
      end
      checks++;
      if (!got || id !== 1'(i % 2) || res !== exp_res || err !== 1'b0) begin
        errors++;
        $display("FAIL fair_txn%0d: got rsp=%b id=%b res=%h exp id=%0d res=%h",
                 i, got, id, res, i % 2, exp_res);
      end
      if (i > 0) begin
        checks++;
        if (at - prev_at != 3) begin
          errors++; $display("FAIL fair_spacing%0d: got %0d cycles exp 3", i, at - prev_at);
        end
      end
      prev_at = at;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fair_no_extra: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    bit ok, got; logic id, err; logic [W-1:0] res; int at;
    rsp_ready = 1'b0;
    issue(1, SRA, 8'h81, 8'h01, ok);
    wait_rsp(got, id, res, err, at);
    checks++;
    if (!ok || !got || id !== 1'b1 || res !== 8'hC0 || err !== 1'b0) begin
      errors++; $display("FAIL bp_first: got ok=%b rsp=%b id=%b res=%h exp id=1 res=c0", ok, got, id, res);
    end
    set_req(0, 1'b1, SLL, 8'h03, 8'h02);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 8'hC0 || rsp_err !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b id=%b res=%h err=%b rdy=%b%b exp v=1 id=1 res=c0 err=0 rdy=00",
                 i, rsp_valid, rsp_id, rsp_result, rsp_err, req0_ready, req1_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req0_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got v=%b rdy0=%b exp v=0 rdy0=1", rsp_valid, req0_ready);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'h0, '0, '0);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_single: got %b exp 0", rsp_valid); end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 8'h0C) begin
      errors++; $display("FAIL bp_pending: got v=%b id=%b res=%h exp v=1 id=0 res=0c", rsp_valid, rsp_id, rsp_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_err_and_mask();
    logic [3:0]   ops [4] = '{4'b0000, SRL, 4'b1111, SRA};
    logic [W-1:0] a   [4] = '{8'hAA, 8'hF0, 8'h55, 8'h70};
    logic [W-1:0] b   [4] = '{8'h01, 8'h0B, 8'h02, 8'hFC};
    logic [W-1:0] exp [4] = '{8'h00, 8'h1E, 8'h00, 8'h07};
    logic         xe  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit ok, got; logic id, err; logic [W-1:0] res; int at;
    for (int i = 0; i < 4; i++) begin
      issue(0, ops[i], a[i], b[i], ok);
      wait_rsp(got, id, res, err, at);
      checks++;
      if (!ok || !got || id !== 1'b0 || res !== exp[i] || err !== xe[i]) begin
        errors++;
        $display("FAIL err_case%0d: got ok=%b rsp=%b id=%b res=%h err=%b exp id=0 res=%h err=%b",
                 i, ok, got, id, res, err, exp[i], xe[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    bit ok, got; logic id, err; logic [W-1:0] res; int at;
    issue(0, SLL, 8'h11, 8'h01, ok);
    rst = 1'b1;
    set_req(0, 1'b1, SLL, 8'h11, 8'h01);
    set_req(1, 1'b1, SRL, 8'h44, 8'h02);
    @(posedge clk); #1;
    checks++;
    if (!ok || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: got ok=%b v=%b rdy=%b%b exp ok=1 v=0 rdy=00",
                         ok, rsp_valid, req0_ready, req1_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_prio: got rdy=%b%b exp 10", req0_ready, req1_ready);
    end
    wait_rsp(got, id, res, err, at);
    checks++;
    if (!got || id !== 1'b0 || res !== 8'h22) begin
      errors++; $display("FAIL rstmid_first: got rsp=%b id=%b res=%h exp id=0 res=22", got, id, res);
    end
    @(posedge clk); #1;
    wait_rsp(got, id, res, err, at);
    set_req(0, 1'b0, 4'h0, '0, '0);
    set_req(1, 1'b0, 4'h0, '0, '0);
    checks++;
    if (!got || id !== 1'b1 || res !== 8'h11) begin
      errors++; $display("FAIL rstmid_second: got rsp=%b id=%b res=%h exp id=1 res=11", got, id, res);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b0, 4'h0, '0, '0);
    set_req(1, 1'b0, 4'h0, '0, '0);
    test_reset();
    test_basic_latency();
    test_req1_ops();
    test_fairness();
    test_backpressure();
    test_err_and_mask();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
